// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter sharing one I2C master between NUM_REQ requesters
//
// Ports:
//   clk, rst (sync, active-low)
//   req/req_addr/req_rw/req_wdata   per-requester level request and command slices
//   gnt/done                        one-hot grant held for the transaction, one-cycle done pulse
//   rdata/ack_err/timeout           response, valid only in the done cycle
//   m_start/m_addr/m_rw/m_wdata     command to the I2C master
//   m_busy/m_done/m_rdata/m_nack    status and response from the I2C master

module i2c_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic                 ack_err,
  output logic                 timeout,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata,
  input  logic                 m_nack
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0]   PTR_MAX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick: first asserted request at or after ptr, wrapping.
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  logic [PTR_W-1:0] next_ptr;
  assign next_ptr = (gidx == PTR_MAX) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
      m_start <= 1'b0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // The command is captured with the grant; later req_* changes are not seen.
          if (pick_found && !m_busy) begin
            gnt     <= GNT_ONE << pick_idx;
            gidx    <= pick_idx;
            m_addr  <= req_addr[7*int'(pick_idx) +: 7];
            m_rw    <= req_rw[pick_idx];
            m_wdata <= req_wdata[8*int'(pick_idx) +: 8];
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // Registered pulse: m_start is high for the first WAIT cycle only.
          m_start <= 1'b1;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          m_start <= 1'b0;
          // m_done has priority over a simultaneous expiry.
          if (m_done) begin
            done    <= gnt;
            rdata   <= m_rdata;
            ack_err <= m_nack;
            timeout <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == CNT_MAX) begin
            done    <= gnt;
            rdata   <= '0;
            ack_err <= 1'b0;
            timeout <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          done    <= '0;
          rdata   <= '0;
          ack_err <= 1'b0;
          timeout <= 1'b0;
          gnt     <= '0;
          ptr     <= next_ptr;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
